// File: rtl/dcache_responder.sv
// dcache_responder
// Data-side responder for the MEM stage. It is a direct-mapped cache with one
// word per line. Writes go through to RAM, and a write miss does not allocate
// a line. A read hit answers in the same cycle. A read miss fills the line
// from RAM and answers in the RAM ACCESS cycle.
//
// Ports
//   CLK, nRST            clock (rising edge), synchronous active-low reset
//   dmemREN/dmemWEN      datapath read/write request, level, held until dhit
//   dmemaddr/dmemstore   word address (bits [1:0] ignored) and write data
//   dhit/dmemload        request done this cycle / read data
//   ramREN/ramWEN        RAM read/write request (mutually exclusive)
//   ramaddr/ramstore     RAM word address / write data
//   ramload/ramstate     RAM read data / 00 FREE 01 BUSY 10 ACCESS 11 ERROR
//   hit_cnt/miss_cnt     saturating read-hit / read-miss counters
module dcache_responder #(
    parameter int SETS = 8
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        dmemREN,
    input  logic        dmemWEN,
    input  logic [31:0] dmemaddr,
    input  logic [31:0] dmemstore,
    output logic        dhit,
    output logic [31:0] dmemload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate,
    output logic [15:0] hit_cnt,
    output logic [15:0] miss_cnt
);
    localparam int IDXW = $clog2(SETS);
    localparam int TAGW = 30 - IDXW;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] RD_MISS = 2'd1;
    localparam logic [1:0] WR      = 2'd2;
    localparam logic [1:0] RS_ACCESS = 2'b10;

    logic [1:0]      state, next_state;
    logic [SETS-1:0] valid;
    logic [TAGW-1:0] tags [SETS];
    logic [31:0]     data [SETS];
    logic [31:0]     laddr, ldata;

    logic [IDXW-1:0] req_idx, lat_idx;
    logic [TAGW-1:0] req_tag, lat_tag;
    logic            req_hit, lat_hit, same_addr, access;
    logic            fill, wr_upd, hit_inc, miss_inc, do_latch;

    assign req_idx   = dmemaddr[2 +: IDXW];
    assign req_tag   = dmemaddr[31 -: TAGW];
    assign lat_idx   = laddr[2 +: IDXW];
    assign lat_tag   = laddr[31 -: TAGW];
    assign req_hit   = valid[req_idx] && (tags[req_idx] == req_tag);
    assign lat_hit   = valid[lat_idx] && (tags[lat_idx] == lat_tag);
    assign same_addr = (dmemaddr[31:2] == laddr[31:2]);
    assign access    = (ramstate == RS_ACCESS);

    // Every output is gated by nRST. This keeps the bus quiet during reset,
    // even while a request is still held.
    always_comb begin
        next_state = state;
        dhit       = 1'b0;
        dmemload   = 32'd0;
        ramREN     = 1'b0;
        ramWEN     = 1'b0;
        ramaddr    = 32'd0;
        ramstore   = 32'd0;
        fill       = 1'b0;
        wr_upd     = 1'b0;
        hit_inc    = 1'b0;
        miss_inc   = 1'b0;
        do_latch   = 1'b0;
        if (nRST) begin
            case (state)
                IDLE: begin
                    if (dmemWEN) begin
                        do_latch   = 1'b1;
                        next_state = WR;
                    end else if (dmemREN) begin
                        if (req_hit) begin
                            dhit     = 1'b1;
                            dmemload = data[req_idx];
                            hit_inc  = 1'b1;
                        end else begin
                            do_latch   = 1'b1;
                            miss_inc   = 1'b1;
                            next_state = RD_MISS;
                        end
                    end
                end
                RD_MISS: begin
                    ramaddr = laddr;
                    // If the datapath drops the request or moves to another
                    // address (for example on a flush), abandon the fill.
                    if (!dmemREN || !same_addr) begin
                        next_state = IDLE;
                    end else begin
                        ramREN = 1'b1;
                        if (access) begin
                            dhit       = 1'b1;
                            dmemload   = ramload;
                            fill       = 1'b1;
                            next_state = IDLE;
                        end
                    end
                end
                WR: begin
                    ramaddr  = laddr;
                    ramstore = ldata;
                    if (!dmemWEN || !same_addr) begin
                        next_state = IDLE;
                    end else begin
                        ramWEN = 1'b1;
                        if (access) begin
                            dhit       = 1'b1;
                            wr_upd     = lat_hit;
                            next_state = IDLE;
                        end
                    end
                end
                default: next_state = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state    <= IDLE;
            valid    <= '0;
            laddr    <= 32'd0;
            ldata    <= 32'd0;
            hit_cnt  <= 16'd0;
            miss_cnt <= 16'd0;
        end else begin
            state <= next_state;
            if (do_latch) begin
                laddr <= dmemaddr;
                if (dmemWEN) ldata <= dmemstore;
            end
            if (fill) valid[lat_idx] <= 1'b1;
            if (hit_inc && hit_cnt != 16'hFFFF) hit_cnt <= hit_cnt + 16'd1;
            if (miss_inc && miss_cnt != 16'hFFFF) miss_cnt <= miss_cnt + 16'd1;
        end
    end

    // The tag and data arrays need no reset because valid qualifies them.
    always_ff @(posedge CLK) begin
        if (fill) begin
            tags[lat_idx] <= lat_tag;
            data[lat_idx] <= ramload;
        end else if (wr_upd) begin
            data[lat_idx] <= ldata;
        end
    end
endmodule

// File: tb/tb_dcache_responder.sv
module tb_dcache_responder;
    localparam logic [1:0] FREE = 2'b00, BUSY = 2'b01, ACCESS = 2'b10;

    logic        CLK, nRST, dmemREN, dmemWEN, dhit, ramREN, ramWEN;
    logic [31:0] dmemaddr, dmemstore, dmemload, ramaddr, ramstore, ramload;
    logic [1:0]  ramstate;
    logic [15:0] hit_cnt, miss_cnt;

    dcache_responder #(.SETS(8)) dut (
        .CLK(CLK), .nRST(nRST), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
        .dmemaddr(dmemaddr), .dmemstore(dmemstore), .dhit(dhit), .dmemload(dmemload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          busy;    // BUSY cycles before ACCESS
        logic [31:0] rdata;   // value RAM returns on ACCESS
        bit          hit;     // expect same-cycle dhit
        logic [31:0] load;    // expected dmemload for reads
        int          hc;      // hit_cnt after txn
        int          mc;      // miss_cnt after txn
    } vec_t;

    vec_t        tbl [13];
    logic [31:0] exp_q [$];
    int          total = 0;
    int          bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // One request: drive it, play RAM (BUSY then ACCESS), and pop the
    // scoreboard entry when dhit appears.
    task automatic txn(input vec_t v);
        int cyc, ren_n, wen_n;
        bit got;
        logic [31:0] exp;
        exp_q.push_back(v.load);
        @(negedge CLK);
        dmemREN = !v.we; dmemWEN = v.we; dmemaddr = v.addr; dmemstore = v.wdata;
        ramstate = FREE; ramload = v.rdata;
        got = 0; cyc = 0; ren_n = 0; wen_n = 0;
        while (!got && cyc < 50) begin
            #1;
            if (ramREN) ren_n++;
            if (ramWEN) wen_n++;
            if (dhit) got = 1;
            else begin
                @(negedge CLK);
                cyc++;
                ramstate = ((ren_n + wen_n) < v.busy) ? BUSY : ACCESS;
            end
        end
        exp = exp_q.pop_front();
        chk("dhit_seen", {31'd0, got}, 32'd1);
        chk("hit_latency0", {31'd0, cyc == 0}, {31'd0, v.hit});
        if (!v.we) chk("dmemload", dmemload, exp);
        chk("ramREN_cycles", ren_n, (v.we || v.hit) ? 0 : v.busy + 1);
        chk("ramWEN_cycles", wen_n, v.we ? v.busy + 1 : 0);
        @(negedge CLK);
        dmemREN = 0; dmemWEN = 0; ramstate = FREE;
        #1;
        chk("hit_cnt", {16'd0, hit_cnt}, v.hc);
        chk("miss_cnt", {16'd0, miss_cnt}, v.mc);
    endtask

    initial begin
        //           we addr     wdata         busy rdata         hit load          hc mc
        tbl[0]  = '{0, 32'h40, 32'h0,        3, 32'hDEADBEEF, 0, 32'hDEADBEEF, 0, 1};
        tbl[1]  = '{0, 32'h40, 32'h0,        0, 32'h0,        1, 32'hDEADBEEF, 1, 1};
        tbl[2]  = '{1, 32'h40, 32'h12345678, 1, 32'h0,        0, 32'h0,        1, 1};
        tbl[3]  = '{0, 32'h40, 32'h0,        0, 32'h0,        1, 32'h12345678, 2, 1};
        tbl[4]  = '{1, 32'h80, 32'hCAFEF00D, 0, 32'h0,        0, 32'h0,        2, 1};
        tbl[5]  = '{0, 32'h80, 32'h0,        0, 32'hAAAA5555, 0, 32'hAAAA5555, 2, 2};
        tbl[6]  = '{0, 32'h00, 32'h0,        2, 32'h11111111, 0, 32'h11111111, 2, 3};
        tbl[7]  = '{0, 32'h20, 32'h0,        0, 32'h22222222, 0, 32'h22222222, 2, 4};
        tbl[8]  = '{0, 32'h00, 32'h0,        1, 32'h33333333, 0, 32'h33333333, 2, 5};
        tbl[9]  = '{0, 32'h04, 32'h0,        0, 32'h44444444, 0, 32'h44444444, 2, 6};
        tbl[10] = '{0, 32'h04, 32'h0,        0, 32'h0,        1, 32'h44444444, 3, 6};
        tbl[11] = '{0, 32'h00, 32'h0,        0, 32'h0,        1, 32'h33333333, 4, 6};
        tbl[12] = '{0, 32'h07, 32'h0,        0, 32'h0,        1, 32'h44444444, 5, 6};

        nRST = 0; dmemREN = 1; dmemWEN = 0; dmemaddr = 32'h40; dmemstore = 0;
        ramstate = FREE; ramload = 0;
        repeat (2) @(negedge CLK);
        #1;
        chk("rst_dhit", {31'd0, dhit}, 32'd0);
        chk("rst_ramREN", {31'd0, ramREN}, 32'd0);
        chk("rst_ramWEN", {31'd0, ramWEN}, 32'd0);
        chk("rst_dmemload", dmemload, 32'd0);
        chk("rst_counts", {hit_cnt, miss_cnt}, 32'd0);
        @(negedge CLK);
        nRST = 1; dmemREN = 0;

        for (int i = 0; i < 13; i++) txn(tbl[i]);

        // Read abort: drop the request while RAM is BUSY.
        @(negedge CLK);
        dmemREN = 1; dmemaddr = 32'h60; #1;
        chk("ab_miss_nohit", {31'd0, dhit}, 32'd0);
        @(negedge CLK);
        ramstate = BUSY; #1;
        chk("ab_ramREN_on", {31'd0, ramREN}, 32'd1);
        @(negedge CLK);
        dmemREN = 0; #1;
        chk("ab_ramREN_drop", {31'd0, ramREN}, 32'd0);
        chk("ab_no_dhit", {31'd0, dhit}, 32'd0);
        @(negedge CLK);
        ramstate = FREE; #1;
        chk("ab_ramREN_idle", {31'd0, ramREN}, 32'd0);
        chk("ab_miss_cnt", {16'd0, miss_cnt}, 32'd7);
        txn('{0, 32'h60, 32'h0, 0, 32'h66666666, 0, 32'h66666666, 5, 8});

        // Write abort: address changes in WR. The cached word must stay unchanged.
        @(negedge CLK);
        dmemWEN = 1; dmemaddr = 32'h04; dmemstore = 32'h99999999; #1;
        chk("wab_nohit", {31'd0, dhit}, 32'd0);
        @(negedge CLK);
        dmemaddr = 32'h08; ramstate = ACCESS; #1;
        chk("wab_ramWEN", {31'd0, ramWEN}, 32'd0);
        chk("wab_dhit", {31'd0, dhit}, 32'd0);
        @(negedge CLK);
        dmemWEN = 0; ramstate = FREE;
        txn('{0, 32'h04, 32'h0, 0, 32'h0, 1, 32'h44444444, 6, 8});

        // Simultaneous read and write: the write path wins.
        @(negedge CLK);
        dmemREN = 1; dmemWEN = 1; dmemaddr = 32'h04; dmemstore = 32'h55555555; #1;
        chk("both_nohit", {31'd0, dhit}, 32'd0);
        chk("both_ramREN0", {31'd0, ramREN}, 32'd0);
        @(negedge CLK);
        ramstate = ACCESS; #1;
        chk("both_ramWEN", {31'd0, ramWEN}, 32'd1);
        chk("both_ramREN1", {31'd0, ramREN}, 32'd0);
        chk("both_dhit", {31'd0, dhit}, 32'd1);
        chk("both_ramstore", ramstore, 32'h55555555);
        @(negedge CLK);
        dmemREN = 0; dmemWEN = 0; ramstate = FREE;
        txn('{0, 32'h04, 32'h0, 0, 32'h0, 1, 32'h55555555, 7, 8});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
